// File: rtl/pe_layer_sequencer_if.sv
// Descriptor handshake and PE config bus for the layer sequencer.
// master: sequencer side (accepts descriptors, drives the cfg bus).
// slave:  environment side (offers descriptors, returns cfg read data).
interface pe_layer_sequencer_if;
    logic        desc_valid;
    logic        desc_ready;
    logic [3:0]  desc_kh;
    logic [3:0]  desc_kw;
    logic [7:0]  desc_in_h;
    logic [7:0]  desc_in_w;
    logic [3:0]  desc_stride;
    logic [3:0]  desc_pad;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;

    modport master (
        input  desc_valid, desc_kh, desc_kw, desc_in_h, desc_in_w, desc_stride, desc_pad,
        input  cfg_rdata,
        output desc_ready, cfg_we, cfg_addr, cfg_wdata
    );

    modport slave (
        output desc_valid, desc_kh, desc_kw, desc_in_h, desc_in_w, desc_stride, desc_pad,
        output cfg_rdata,
        input  desc_ready, cfg_we, cfg_addr, cfg_wdata
    );
endinterface

// File: rtl/pe_layer_sequencer.sv
// Layer sequencer: takes one convolution descriptor, derives output size with a serial
// subtractive divider, programs the PE config registers, starts it and polls for done.
// Optional macro SEQ_TIMEOUT_EN adds a POLL timeout counter (err_code 2'b10).
module pe_layer_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pe_layer_sequencer_if.master bus,
    input  logic                 abort,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [7:0]           out_h,
    output logic [7:0]           out_w
);

    typedef enum logic [3:0] {
        StIdle, StCalc, StWrKern, StWrIn, StWrSp, StWrOut, StStart, StPoll, StDone, StErr
    } state_e;

    // in + 2*pad - k, wide enough that the geometry checks never overflow
    function automatic logic [9:0] span(input logic [7:0] dim, input logic [3:0] pad,
                                        input logic [3:0] k);
        return {2'b00, dim} + {5'b0, pad, 1'b0} - {6'b0, k};
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  kh_q, kh_d, kw_q, kw_d, stride_q, stride_d, pad_q, pad_d;
    logic [7:0]  in_h_q, in_h_d, in_w_q, in_w_d;
    logic [8:0]  n_h_q, n_h_d, n_w_q, n_w_d;
    logic [7:0]  q_h_q, q_h_d, q_w_q, q_w_d;
    logic [7:0]  out_h_q, out_h_d, out_w_q, out_w_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        poll_seen_q;
    logic        desc_ready;
    logic        timeout;
    logic [9:0]  ext_h, ext_w, num_h, num_w;
    logic [11:0] out_lim;
    logic        geom_bad, h_go, w_go;
    logic        unused_rdata;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [16:0] TimeoutLast = 17'(TIMEOUT_CYCLES - 1);
    logic [16:0] to_cnt_q, to_cnt_d;

    // Counter restarts on every POLL entry and runs while polling
    always_comb begin
        to_cnt_d = (state_q == StPoll) ? to_cnt_q + 17'd1 : 17'd0;
    end

    assign timeout = (state_q == StPoll) && (to_cnt_q == TimeoutLast);

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= 17'd0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    logic unused_timeout_param;
    assign timeout              = 1'b0;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    assign unused_rdata = ^bus.cfg_rdata[31:1];
    assign desc_ready   = (state_q == StIdle) && !abort;

    // Geometry of the latched descriptor; constant for the whole CALC phase
    always_comb begin
        ext_h    = {2'b00, in_h_q} + {5'b0, pad_q, 1'b0};
        ext_w    = {2'b00, in_w_q} + {5'b0, pad_q, 1'b0};
        num_h    = span(in_h_q, pad_q, kh_q);
        num_w    = span(in_w_q, pad_q, kw_q);
        // output > 255 exactly when num >= 255 * stride
        out_lim  = {8'b0, stride_q} * 12'd255;
        geom_bad = (stride_q == 4'd0) || (kh_q == 4'd0) || (kw_q == 4'd0) ||
                   (ext_h < {6'b0, kh_q}) || (ext_w < {6'b0, kw_q}) ||
                   ({2'b00, num_h} >= out_lim) || ({2'b00, num_w} >= out_lim);
        h_go     = n_h_q >= {5'b0, stride_q};
        w_go     = n_w_q >= {5'b0, stride_q};
    end

    // Next-state, descriptor latch and divider step
    always_comb begin
        state_d    = state_q;
        kh_d       = kh_q;
        kw_d       = kw_q;
        stride_d   = stride_q;
        pad_d      = pad_q;
        in_h_d     = in_h_q;
        in_w_d     = in_w_q;
        n_h_d      = n_h_q;
        n_w_d      = n_w_q;
        q_h_d      = q_h_q;
        q_w_d      = q_w_q;
        out_h_d    = out_h_q;
        out_w_d    = out_w_q;
        err_code_d = err_code_q;
        if (state_q != StIdle && abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.desc_valid && desc_ready) begin
                        kh_d       = bus.desc_kh;
                        kw_d       = bus.desc_kw;
                        stride_d   = bus.desc_stride;
                        pad_d      = bus.desc_pad;
                        in_h_d     = bus.desc_in_h;
                        in_w_d     = bus.desc_in_w;
                        n_h_d      = 9'(span(bus.desc_in_h, bus.desc_pad, bus.desc_kh));
                        n_w_d      = 9'(span(bus.desc_in_w, bus.desc_pad, bus.desc_kw));
                        q_h_d      = 8'd0;
                        q_w_d      = 8'd0;
                        err_code_d = 2'b00;
                        state_d    = StCalc;
                    end
                end
                StCalc: begin
                    if (geom_bad) begin
                        err_code_d = 2'b01;
                        state_d    = StErr;
                    end else if (h_go || w_go) begin
                        if (h_go) begin
                            n_h_d = n_h_q - {5'b0, stride_q};
                            q_h_d = q_h_q + 8'd1;
                        end
                        if (w_go) begin
                            n_w_d = n_w_q - {5'b0, stride_q};
                            q_w_d = q_w_q + 8'd1;
                        end
                    end else begin
                        out_h_d = q_h_q + 8'd1;
                        out_w_d = q_w_q + 8'd1;
                        state_d = StWrKern;
                    end
                end
                StWrKern: state_d = StWrIn;
                StWrIn:   state_d = StWrSp;
                StWrSp:   state_d = StWrOut;
                StWrOut:  state_d = StStart;
                StStart:  state_d = StPoll;
                StPoll: begin
                    // first POLL cycle may still see the previous layer's done bit
                    if (poll_seen_q && bus.cfg_rdata[0]) begin
                        state_d = StDone;
                    end else if (timeout) begin
                        err_code_d = 2'b10;
                        state_d    = StErr;
                    end
                end
                StDone:  state_d = StIdle;
                StErr:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 4'd1;
        bus.cfg_wdata = 32'd0;
        unique case (state_q)
            StWrKern: begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd2;
                bus.cfg_wdata = {20'b0, kh_q, 4'b0, kw_q};
            end
            StWrIn: begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd3;
                bus.cfg_wdata = {16'b0, in_h_q, in_w_q};
            end
            StWrSp: begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd4;
                bus.cfg_wdata = {24'b0, pad_q, stride_q};
            end
            StWrOut: begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd5;
                bus.cfg_wdata = {16'b0, out_h_q, out_w_q};
            end
            StStart: begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd0;
                bus.cfg_wdata = 32'h1;
            end
            default: ;
        endcase
    end

    assign bus.desc_ready = desc_ready;
    assign busy           = (state_q != StIdle);
    assign layer_done     = (state_q == StDone);
    assign err            = (state_q == StErr);
    assign err_code       = err_code_q;
    assign out_h          = out_h_q;
    assign out_w          = out_w_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            kh_q        <= 4'd0;
            kw_q        <= 4'd0;
            stride_q    <= 4'd0;
            pad_q       <= 4'd0;
            in_h_q      <= 8'd0;
            in_w_q      <= 8'd0;
            n_h_q       <= 9'd0;
            n_w_q       <= 9'd0;
            q_h_q       <= 8'd0;
            q_w_q       <= 8'd0;
            out_h_q     <= 8'd0;
            out_w_q     <= 8'd0;
            err_code_q  <= 2'b00;
            poll_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kh_q        <= kh_d;
            kw_q        <= kw_d;
            stride_q    <= stride_d;
            pad_q       <= pad_d;
            in_h_q      <= in_h_d;
            in_w_q      <= in_w_d;
            n_h_q       <= n_h_d;
            n_w_q       <= n_w_d;
            q_h_q       <= q_h_d;
            q_w_q       <= q_w_d;
            out_h_q     <= out_h_d;
            out_w_q     <= out_w_d;
            err_code_q  <= err_code_d;
            poll_seen_q <= (state_q == StPoll);
        end
    end

endmodule
